// File: rtl/core_pkg.sv
// Shared types for the hazard/forwarding controller: forwarding select codes,
// controller FSM states and the source/destination register match helper.
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    NO_FORWARD_SELECT = 2'd0,
    EX_RESULT_SELECT  = 2'd1,
    MEM_RESULT_SELECT = 2'd2
  } forward_mux_code;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hazard_state_e;

  // A source depends on a producer only if it is read, is not x0, and the
  // producer actually writes that register.
  function automatic logic src_match(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] rd,
    input logic                  wr
  );
    return used && wr && (src != '0) && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_reg_match.sv
// Compares one Decode source register against the EX and MEM shadow
// destinations and returns the forwarding select plus a load-use flag.
module hazard_reg_match
  import core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr_i,
  input  logic                  src_used_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_wr_i,
  input  logic                  ex_load_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_wr_i,
  output forward_mux_code       sel_o,
  output logic                  load_use_o
);

  logic hit_ex;
  logic hit_mem;

  // Nearer producer wins; a load still in EX has no data yet, so it blocks
  // the older MEM value and raises load-use instead.
  always_comb begin
    hit_ex     = src_match(src_used_i, src_addr_i, ex_rd_i, ex_wr_i);
    hit_mem    = src_match(src_used_i, src_addr_i, mem_rd_i, mem_wr_i);
    sel_o      = NO_FORWARD_SELECT;
    load_use_o = 1'b0;
    if (hit_ex) begin
      if (ex_load_i) begin
        load_use_o = 1'b1;
      end else begin
        sel_o = EX_RESULT_SELECT;
      end
    end else if (hit_mem) begin
      sel_o = MEM_RESULT_SELECT;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: tracks EX/MEM destinations in shadow
// registers, drives registered EX forwarding selects, load-use stalls,
// redirect flushes and saturating stall/flush event counters.
module hazard_fwd_ctrl
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid_ip,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_ip,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_ip,
  input  logic                  id_rs1_used_ip,
  input  logic                  id_rs2_used_ip,
  input  logic [REG_ADDR_W-1:0] id_write_reg_addr_ip,
  input  logic                  id_reg_write_ip,
  input  logic                  id_is_load_ip,
  input  logic                  next_PC_addr_valid_ip,
  output forward_mux_code       fa_mux_op,
  output forward_mux_code       fb_mux_op,
  output logic                  stall_op,
  output logic                  flush_op,
  output logic [CNT_W-1:0]      stall_cnt_op,
  output logic [CNT_W-1:0]      flush_cnt_op
);

  hazard_state_e         state_q, state_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic                  ex_wr_q, ex_wr_d, ex_load_q, ex_load_d;
  logic                  mem_wr_q, mem_wr_d;
  forward_mux_code       fa_q, fa_d, fb_q, fb_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  forward_mux_code       sel1, sel2;
  logic                  lu1, lu2;
  logic                  stall, flush;

  hazard_reg_match u_match_rs1 (
    .src_addr_i (id_rs1_addr_ip),
    .src_used_i (id_rs1_used_ip),
    .ex_rd_i    (ex_rd_q),
    .ex_wr_i    (ex_wr_q),
    .ex_load_i  (ex_load_q),
    .mem_rd_i   (mem_rd_q),
    .mem_wr_i   (mem_wr_q),
    .sel_o      (sel1),
    .load_use_o (lu1)
  );

  hazard_reg_match u_match_rs2 (
    .src_addr_i (id_rs2_addr_ip),
    .src_used_i (id_rs2_used_ip),
    .ex_rd_i    (ex_rd_q),
    .ex_wr_i    (ex_wr_q),
    .ex_load_i  (ex_load_q),
    .mem_rd_i   (mem_rd_q),
    .mem_wr_i   (mem_wr_q),
    .sel_o      (sel2),
    .load_use_o (lu2)
  );

  // Same-cycle hazard decisions; reset masks both, flush overrides stall and
  // the LOAD_STALL state blocks a second stall for the same load-use pair.
  always_comb begin
    flush = reset && next_PC_addr_valid_ip;
    stall = reset && id_valid_ip && !flush && (lu1 || lu2) &&
            (state_q != LOAD_STALL);
  end

  assign stall_op = stall;
  assign flush_op = flush;

  // Next state, shadow pipeline, EX selects and counters.
  always_comb begin
    state_d     = RUN;
    ex_rd_d     = id_write_reg_addr_ip;
    ex_wr_d     = id_valid_ip && id_reg_write_ip;
    ex_load_d   = id_valid_ip && id_is_load_ip;
    mem_rd_d    = ex_rd_q;
    mem_wr_d    = ex_wr_q;
    fa_d        = sel1;
    fb_d        = sel2;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (flush) begin
      state_d = FLUSH;
    end else if (stall) begin
      state_d = LOAD_STALL;
    end

    if (flush || stall) begin
      ex_rd_d   = '0;
      ex_wr_d   = 1'b0;
      ex_load_d = 1'b0;
      fa_d      = NO_FORWARD_SELECT;
      fb_d      = NO_FORWARD_SELECT;
    end

    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RUN;
      ex_rd_q     <= '0;
      ex_wr_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_rd_q    <= '0;
      mem_wr_q    <= 1'b0;
      fa_q        <= NO_FORWARD_SELECT;
      fb_q        <= NO_FORWARD_SELECT;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_rd_q     <= ex_rd_d;
      ex_wr_q     <= ex_wr_d;
      ex_load_q   <= ex_load_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fa_mux_op    = fa_q;
  assign fb_mux_op    = fb_q;
  assign stall_cnt_op = stall_cnt_q;
  assign flush_cnt_op = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding, load-use, x0, redirects,
// counter saturation (on a narrow-counter instance) and mid-stall reset.
module tb_hazard_fwd_ctrl;
  import core_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [4:0]      rs1, rs2, rd;
  logic            u1, u2, wr, ld;
  logic            redir;
  forward_mux_code fa, fb, fa_s, fb_s;
  logic            stall, flush, stall_s, flush_s;
  logic [15:0]     stall_cnt, flush_cnt;
  logic [1:0]      stall_cnt_s, flush_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hazard_fwd_ctrl #(.CNT_W(16)) u_dut (
    .clock (clock), .reset (reset), .id_valid_ip (id_valid),
    .id_rs1_addr_ip (rs1), .id_rs2_addr_ip (rs2),
    .id_rs1_used_ip (u1), .id_rs2_used_ip (u2),
    .id_write_reg_addr_ip (rd), .id_reg_write_ip (wr), .id_is_load_ip (ld),
    .next_PC_addr_valid_ip (redir),
    .fa_mux_op (fa), .fb_mux_op (fb), .stall_op (stall), .flush_op (flush),
    .stall_cnt_op (stall_cnt), .flush_cnt_op (flush_cnt)
  );

  hazard_fwd_ctrl #(.CNT_W(2)) u_dut_sat (
    .clock (clock), .reset (reset), .id_valid_ip (id_valid),
    .id_rs1_addr_ip (rs1), .id_rs2_addr_ip (rs2),
    .id_rs1_used_ip (u1), .id_rs2_used_ip (u2),
    .id_write_reg_addr_ip (rd), .id_reg_write_ip (wr), .id_is_load_ip (ld),
    .next_PC_addr_valid_ip (redir),
    .fa_mux_op (fa_s), .fb_mux_op (fb_s), .stall_op (stall_s), .flush_op (flush_s),
    .stall_cnt_op (stall_cnt_s), .flush_cnt_op (flush_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic id(input logic v, input logic [4:0] a1, input logic e1,
                    input logic [4:0] a2, input logic e2,
                    input logic [4:0] d, input logic w, input logic l);
    id_valid = v; rs1 = a1; u1 = e1; rs2 = a2; u2 = e2; rd = d; wr = w; ld = l;
  endtask

  initial begin
    reset = 1'b0;
    redir = 1'b1;
    id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
    #1;
    check("reset_flush_masked", 32'(flush), 32'd0);
    cyc(); cyc();
    check("reset_fa", 32'(fa), 32'(NO_FORWARD_SELECT));
    check("reset_fb", 32'(fb), 32'(NO_FORWARD_SELECT));
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    reset = 1'b1;
    redir = 1'b0;

    // ADD x5,x1,x2 ; ADD x6,x5,x5 -> EX forwarding on both operands
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc();
    id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    check("ex_fwd_no_stall", 32'(stall), 32'd0);
    cyc();
    check("ex_fwd_fa", 32'(fa), 32'(EX_RESULT_SELECT));
    check("ex_fwd_fb", 32'(fb), 32'(EX_RESULT_SELECT));
    check("ex_fwd_fa_sat_inst", 32'(fa_s), 32'(EX_RESULT_SELECT));

    // ADD x5,x1,x2 ; NOP ; SUB x7,x5,x1 -> MEM forwarding on rs1 only
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc();
    id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc();
    id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
    cyc();
    check("mem_fwd_fa", 32'(fa), 32'(MEM_RESULT_SELECT));
    check("mem_fwd_fb", 32'(fb), 32'(NO_FORWARD_SELECT));

    // LW x5,0(x2) ; ADD x6,x5,x0 -> one bubble then MEM forwarding
    id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    #1;
    check("lw_issue_no_stall", 32'(stall), 32'd0);
    cyc();
    id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    check("lu_stall", 32'(stall), 32'd1);
    cyc();
    check("lu_bubble_fa", 32'(fa), 32'(NO_FORWARD_SELECT));
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    #1;
    check("lu_stall_once", 32'(stall), 32'd0);
    cyc();
    check("lu_after_fa", 32'(fa), 32'(MEM_RESULT_SELECT));
    check("lu_after_fb", 32'(fb), 32'(NO_FORWARD_SELECT));
    check("lu_stall_cnt_hold", 32'(stall_cnt), 32'd1);

    // ADD x0,x3,x4 ; ADD x8,x0,x0 ; ADD x9,x0,x0 -> x0 never forwards
    id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b1, 1'b0);
    cyc();
    id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    cyc();
    check("x0_ex_fa", 32'(fa), 32'(NO_FORWARD_SELECT));
    check("x0_ex_fb", 32'(fb), 32'(NO_FORWARD_SELECT));
    id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    cyc();
    check("x0_mem_fa", 32'(fa), 32'(NO_FORWARD_SELECT));
    check("x0_mem_fb", 32'(fb), 32'(NO_FORWARD_SELECT));

    // LW x9 ; ADD x10,x9,x9 with a coincident redirect -> flush wins
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    cyc();
    id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
    redir = 1'b1;
    #1;
    check("redir_flush", 32'(flush), 32'd1);
    check("redir_no_stall", 32'(stall), 32'd0);
    cyc();
    check("redir_fa", 32'(fa), 32'(NO_FORWARD_SELECT));
    check("redir_fb", 32'(fb), 32'(NO_FORWARD_SELECT));
    check("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    redir = 1'b0;
    id(1'b1, 5'd9, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0);
    #1;
    check("post_flush_flush", 32'(flush), 32'd0);
    check("post_flush_stall", 32'(stall), 32'd0);
    cyc();
    check("post_flush_fa", 32'(fa), 32'(MEM_RESULT_SELECT));
    check("post_flush_cnt_hold", 32'(flush_cnt), 32'd1);

    // LW x12 ; ADD rs1=x12 -> stall, then redirect during LOAD_STALL
    id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    cyc();
    id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    #1;
    check("ls_redir_stall", 32'(stall), 32'd1);
    cyc();
    check("ls_redir_stall_cnt", 32'(stall_cnt), 32'd2);
    redir = 1'b1;
    #1;
    check("ls_redir_flush", 32'(flush), 32'd1);
    check("ls_redir_no_stall", 32'(stall), 32'd0);
    cyc();
    check("ls_redir_flush_cnt", 32'(flush_cnt), 32'd2);
    check("ls_redir_fa", 32'(fa), 32'(NO_FORWARD_SELECT));

    // Two back-to-back redirects: each is a flush cycle
    id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("redir2_a", 32'(flush), 32'd1);
    cyc();
    #1;
    check("redir2_b", 32'(flush), 32'd1);
    cyc();
    redir = 1'b0;
    check("flush_cnt_4", 32'(flush_cnt), 32'd4);
    check("flush_cnt_sat", 32'(flush_cnt_s), 32'd3);
    check("stall_cnt_sat_pre", 32'(stall_cnt_s), 32'd2);

    // Three more load-use stalls: narrow counter goes 2 -> 3 and holds
    for (int k = 0; k < 3; k++) begin
      id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
      #1;
      check("loop_lw_no_stall", 32'(stall), 32'd0);
      cyc();
      id(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
      #1;
      check("loop_stall", 32'(stall), 32'd1);
      cyc();
      #1;
      check("loop_stall_once", 32'(stall), 32'd0);
      cyc();
      check("loop_fa", 32'(fa), 32'(MEM_RESULT_SELECT));
    end
    check("stall_cnt_5", 32'(stall_cnt), 32'd5);
    check("stall_cnt_sat", 32'(stall_cnt_s), 32'd3);

    // Reset asserted in LOAD_STALL with a redirect pending
    id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1);
    cyc();
    id(1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
    #1;
    check("rst_mid_stall_pre", 32'(stall), 32'd1);
    cyc();
    reset = 1'b0;
    redir = 1'b1;
    #1;
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_flush", 32'(flush), 32'd0);
    cyc();
    check("rst_mid_fa", 32'(fa), 32'(NO_FORWARD_SELECT));
    check("rst_mid_fb", 32'(fb), 32'(NO_FORWARD_SELECT));
    check("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_mid_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_mid_sat_cnt", 32'(stall_cnt_s), 32'd0);
    reset = 1'b1;
    redir = 1'b0;
    #1;
    check("rst_shadow_no_stall", 32'(stall), 32'd0);
    cyc();
    check("rst_shadow_fa", 32'(fa), 32'(NO_FORWARD_SELECT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
